// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exception / mret / interrupt, drains the
// pipeline, commits the trap CSR update in one pulse and redirects fetch.

package enums;
   typedef enum logic [31:0] {
      MCAUSE_INSTR_MISALIGNED = 32'h0000_0000,
      MCAUSE_INSTR_FAULT      = 32'h0000_0001,
      MCAUSE_ILLEGAL_INSTR    = 32'h0000_0002,
      MCAUSE_BREAKPOINT       = 32'h0000_0003,
      MCAUSE_LOAD_MISALIGNED  = 32'h0000_0004,
      MCAUSE_LOAD_FAULT       = 32'h0000_0005,
      MCAUSE_STORE_MISALIGNED = 32'h0000_0006,
      MCAUSE_STORE_FAULT      = 32'h0000_0007,
      MCAUSE_ECALL_M          = 32'h0000_000B,
      MCAUSE_MSI              = 32'h8000_0003,
      MCAUSE_MTI              = 32'h8000_0007,
      MCAUSE_MEI              = 32'h8000_000B
   } mcause_t;
endpackage

module trap_ctrl
   import enums::*;
#(
   parameter int DRAIN_TIMEOUT = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         exc_valid_i,
   input  mcause_t      exc_cause_i,
   input  logic [31:0]  exc_pc_i,
   input  logic [31:0]  exc_tval_i,
   input  logic         mret_valid_i,
   input  logic         bnd_valid_i,
   input  logic [31:0]  bnd_pc_i,
   output logic         evt_ready_o,
   input  logic         mie_i,
   input  logic         mpie_i,
   input  logic         meip_i,
   input  logic         msip_i,
   input  logic         mtip_i,
   input  logic         meie_i,
   input  logic         msie_i,
   input  logic         mtie_i,
   input  logic [29:0]  mtvec_base_i,
   input  logic [31:0]  mepc_i,
   output logic         flush_req_o,
   input  logic         flush_ack_i,
   output logic         csr_trap_we_o,
   output logic [31:0]  mepc_wd_o,
   output mcause_t      mcause_wd_o,
   output logic [31:0]  mtval_wd_o,
   output logic         mie_wd_o,
   output logic         mpie_wd_o,
   output logic         redir_valid_o,
   output logic [31:0]  redir_pc_o,
   input  logic         redir_ready_i,
   output logic         drain_timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_COMMIT   = 2'd2,
      ST_REDIRECT = 2'd3
   } state_t;

   localparam logic [4:0] LAST_CNT = 5'(DRAIN_TIMEOUT - 1);

   state_t       state_q;
   logic [4:0]   cnt_q;
   logic         is_mret_q;
   mcause_t      cause_q;
   logic [31:0]  pc_q;
   logic [31:0]  tval_q;
   logic         mie_q;
   logic         mpie_q;
   logic [29:0]  mtvec_q;

   logic         evt_ready_q;
   logic         flush_req_q;
   logic         csr_trap_we_q;
   logic [31:0]  mepc_wd_q;
   mcause_t      mcause_wd_q;
   logic [31:0]  mtval_wd_q;
   logic         mie_wd_q;
   logic         mpie_wd_q;
   logic         redir_valid_q;
   logic [31:0]  redir_pc_q;
   logic         drain_timeout_q;

   logic [2:0]   irq_hit;
   logic         accept_d;
   logic         is_mret_d;
   mcause_t      cause_d;
   logic [31:0]  pc_d;
   logic [31:0]  tval_d;

   assign irq_hit = {meip_i & meie_i, msip_i & msie_i, mtip_i & mtie_i};

   // Event selection: exception > mret > interrupt (MEI > MSI > MTI).
   always_comb begin
      accept_d  = 1'b0;
      is_mret_d = 1'b0;
      cause_d   = MCAUSE_INSTR_MISALIGNED;
      pc_d      = 32'd0;
      tval_d    = 32'd0;
      if (exc_valid_i) begin
         accept_d = 1'b1;
         cause_d  = exc_cause_i;
         pc_d     = exc_pc_i;
         tval_d   = exc_tval_i;
      end else if (mret_valid_i) begin
         accept_d  = 1'b1;
         is_mret_d = 1'b1;
         pc_d      = mepc_i;
      end else if (bnd_valid_i && mie_i && (irq_hit != 3'b000)) begin
         accept_d = 1'b1;
         pc_d     = bnd_pc_i;
         if (irq_hit[2]) begin
            cause_d = MCAUSE_MEI;
         end else if (irq_hit[1]) begin
            cause_d = MCAUSE_MSI;
         end else begin
            cause_d = MCAUSE_MTI;
         end
      end else begin
         accept_d = 1'b0;
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         cnt_q           <= 5'd0;
         is_mret_q       <= 1'b0;
         cause_q         <= MCAUSE_INSTR_MISALIGNED;
         pc_q            <= 32'd0;
         tval_q          <= 32'd0;
         mie_q           <= 1'b0;
         mpie_q          <= 1'b0;
         mtvec_q         <= 30'd0;
         evt_ready_q     <= 1'b1;
         flush_req_q     <= 1'b0;
         csr_trap_we_q   <= 1'b0;
         mepc_wd_q       <= 32'd0;
         mcause_wd_q     <= MCAUSE_INSTR_MISALIGNED;
         mtval_wd_q      <= 32'd0;
         mie_wd_q        <= 1'b0;
         mpie_wd_q       <= 1'b0;
         redir_valid_q   <= 1'b0;
         redir_pc_q      <= 32'd0;
         drain_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_d) begin
                  // CSR-side inputs are only trusted while ready, so capture them now.
                  state_q     <= ST_DRAIN;
                  cnt_q       <= 5'd0;
                  is_mret_q   <= is_mret_d;
                  cause_q     <= cause_d;
                  pc_q        <= pc_d;
                  tval_q      <= tval_d;
                  mie_q       <= mie_i;
                  mpie_q      <= mpie_i;
                  mtvec_q     <= mtvec_base_i;
                  evt_ready_q <= 1'b0;
                  flush_req_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (flush_ack_i || (cnt_q == LAST_CNT)) begin
                  state_q       <= ST_COMMIT;
                  flush_req_q   <= 1'b0;
                  csr_trap_we_q <= 1'b1;
                  if (!flush_ack_i) begin
                     drain_timeout_q <= 1'b1;
                  end
                  mepc_wd_q <= {pc_q[31:2], 2'b00};
                  // mret leaves mcause/mtval at the last values this block wrote.
                  if (is_mret_q) begin
                     mie_wd_q   <= mpie_q;
                     mpie_wd_q  <= 1'b1;
                     redir_pc_q <= pc_q;
                  end else begin
                     mcause_wd_q <= cause_q;
                     mtval_wd_q  <= tval_q;
                     mpie_wd_q   <= mie_q;
                     mie_wd_q    <= 1'b0;
                     redir_pc_q  <= {mtvec_q, 2'b00};
                  end
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            ST_COMMIT: begin
               state_q       <= ST_REDIRECT;
               csr_trap_we_q <= 1'b0;
               redir_valid_q <= 1'b1;
            end
            ST_REDIRECT: begin
               if (redir_ready_i) begin
                  state_q       <= ST_IDLE;
                  redir_valid_q <= 1'b0;
                  evt_ready_q   <= 1'b1;
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               evt_ready_q   <= 1'b1;
               flush_req_q   <= 1'b0;
               csr_trap_we_q <= 1'b0;
               redir_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign evt_ready_o     = evt_ready_q;
   assign flush_req_o     = flush_req_q;
   assign csr_trap_we_o   = csr_trap_we_q;
   assign mepc_wd_o       = mepc_wd_q;
   assign mcause_wd_o     = mcause_wd_q;
   assign mtval_wd_o      = mtval_wd_q;
   assign mie_wd_o        = mie_wd_q;
   assign mpie_wd_o       = mpie_wd_q;
   assign redir_valid_o   = redir_valid_q;
   assign redir_pc_o      = redir_pc_q;
   assign drain_timeout_o = drain_timeout_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: hand-computed expectations checked with immediate assertions.

module tb_trap_ctrl;
   import enums::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         exc_valid;
   mcause_t      exc_cause;
   logic [31:0]  exc_pc;
   logic [31:0]  exc_tval;
   logic         mret_valid;
   logic         bnd_valid;
   logic [31:0]  bnd_pc;
   logic         evt_ready;
   logic         mie, mpie;
   logic         meip, msip, mtip, meie, msie, mtie;
   logic [29:0]  mtvec_base;
   logic [31:0]  mepc;
   logic         flush_req;
   logic         flush_ack;
   logic         csr_trap_we;
   logic [31:0]  mepc_wd;
   mcause_t      mcause_wd;
   logic [31:0]  mtval_wd;
   logic         mie_wd, mpie_wd;
   logic         redir_valid;
   logic [31:0]  redir_pc;
   logic         redir_ready;
   logic         drain_timeout;

   int n_pass  = 0;
   int n_total = 0;

   trap_ctrl #(.DRAIN_TIMEOUT(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .exc_valid_i(exc_valid), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc), .exc_tval_i(exc_tval),
      .mret_valid_i(mret_valid), .bnd_valid_i(bnd_valid), .bnd_pc_i(bnd_pc),
      .evt_ready_o(evt_ready), .mie_i(mie), .mpie_i(mpie),
      .meip_i(meip), .msip_i(msip), .mtip_i(mtip), .meie_i(meie), .msie_i(msie), .mtie_i(mtie),
      .mtvec_base_i(mtvec_base), .mepc_i(mepc),
      .flush_req_o(flush_req), .flush_ack_i(flush_ack),
      .csr_trap_we_o(csr_trap_we), .mepc_wd_o(mepc_wd), .mcause_wd_o(mcause_wd),
      .mtval_wd_o(mtval_wd), .mie_wd_o(mie_wd), .mpie_wd_o(mpie_wd),
      .redir_valid_o(redir_valid), .redir_pc_o(redir_pc), .redir_ready_i(redir_ready),
      .drain_timeout_o(drain_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic clear_events();
      exc_valid = 1'b0; mret_valid = 1'b0; bnd_valid = 1'b0;
      meip = 1'b0; msip = 1'b0; mtip = 1'b0;
      meie = 1'b0; msie = 1'b0; mtie = 1'b0;
   endtask

   // From REDIRECT: accept the redirect and expect a return to IDLE.
   task automatic finish_redirect(input string tag);
      redir_ready = 1'b1;
      tick();
      chk1({tag, "_idle_ready"}, evt_ready, 1'b1);
      chk1({tag, "_idle_rv"}, redir_valid, 1'b0);
      redir_ready = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      clear_events();
      exc_cause = MCAUSE_INSTR_MISALIGNED; exc_pc = 32'd0; exc_tval = 32'd0; bnd_pc = 32'd0;
      mie = 1'b0; mpie = 1'b0; mtvec_base = 30'd0; mepc = 32'd0;
      flush_ack = 1'b0; redir_ready = 1'b0;
      tick();
      tick();
      chk1("rst_ready", evt_ready, 1'b1);
      chk1("rst_flush", flush_req, 1'b0);
      chk1("rst_we", csr_trap_we, 1'b0);
      chk1("rst_rv", redir_valid, 1'b0);
      chk1("rst_to", drain_timeout, 1'b0);
      chk("rst_mepc", mepc_wd, 32'h0);
      chk("rst_rpc", redir_pc, 32'h0);
      rst = 1'b0;
      tick();

      // 1: illegal instruction, flush_ack in first DRAIN cycle
      exc_valid = 1'b1; exc_cause = MCAUSE_ILLEGAL_INSTR; exc_pc = 32'h100; exc_tval = 32'hDEAD;
      mie = 1'b1; mpie = 1'b0; mtvec_base = 30'h80;
      tick();
      chk1("t1_drain_ready", evt_ready, 1'b0);
      chk1("t1_drain_flush", flush_req, 1'b1);
      chk1("t1_drain_we", csr_trap_we, 1'b0);
      exc_valid = 1'b0; flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      chk1("t1_we", csr_trap_we, 1'b1);
      chk1("t1_flush0", flush_req, 1'b0);
      chk("t1_mepc", mepc_wd, 32'h100);
      chk("t1_mcause", mcause_wd, 32'h2);
      chk("t1_mtval", mtval_wd, 32'hDEAD);
      chk1("t1_mpie", mpie_wd, 1'b1);
      chk1("t1_mie", mie_wd, 1'b0);
      chk("t1_rpc", redir_pc, 32'h200);
      chk1("t1_to", drain_timeout, 1'b0);
      tick();
      chk1("t1_we_pulse", csr_trap_we, 1'b0);
      chk1("t1_rv", redir_valid, 1'b1);
      finish_redirect("t1");

      // 2a: MEI beats MTI; irq changes after accept are ignored
      bnd_valid = 1'b1; bnd_pc = 32'h44; meip = 1'b1; mtip = 1'b1; meie = 1'b1; mtie = 1'b1; mie = 1'b1;
      tick();
      chk1("t2_flush", flush_req, 1'b1);
      clear_events();
      msip = 1'b1; msie = 1'b1;
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      clear_events();
      chk1("t2_we", csr_trap_we, 1'b1);
      chk("t2_mcause", mcause_wd, 32'h8000_000B);
      chk("t2_mepc", mepc_wd, 32'h44);
      chk("t2_mtval", mtval_wd, 32'h0);
      tick();
      finish_redirect("t2");

      // 2b: same stimulus with mie=0 is ignored
      bnd_valid = 1'b1; bnd_pc = 32'h44; meip = 1'b1; mtip = 1'b1; meie = 1'b1; mtie = 1'b1; mie = 1'b0;
      tick();
      chk1("t2b_ready", evt_ready, 1'b1);
      chk1("t2b_flush", flush_req, 1'b0);
      tick();
      chk1("t2b_flush2", flush_req, 1'b0);
      clear_events();

      // 2c: disabled MEI skipped, MSI beats MTI
      bnd_valid = 1'b1; bnd_pc = 32'h48; mie = 1'b1;
      meip = 1'b1; msip = 1'b1; msie = 1'b1; mtip = 1'b1; mtie = 1'b1;
      tick();
      clear_events();
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      chk("t2c_mcause", mcause_wd, 32'h8000_0003);
      chk("t2c_mepc", mepc_wd, 32'h48);
      tick();
      finish_redirect("t2c");

      // 3a: mret wins over a takeable interrupt
      mret_valid = 1'b1; mpie = 1'b1; mie = 1'b1; mepc = 32'h80;
      bnd_valid = 1'b1; bnd_pc = 32'h60; mtip = 1'b1; mtie = 1'b1;
      tick();
      clear_events();
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      chk1("t3_we", csr_trap_we, 1'b1);
      chk1("t3_mie", mie_wd, 1'b1);
      chk1("t3_mpie", mpie_wd, 1'b1);
      chk("t3_rpc", redir_pc, 32'h80);
      chk("t3_mepc", mepc_wd, 32'h80);
      chk("t3_mcause_kept", mcause_wd, 32'h8000_0003);
      tick();
      finish_redirect("t3");

      // 3b: exception with mret in the same cycle; mepc low bits cleared
      mret_valid = 1'b1; exc_valid = 1'b1; exc_cause = MCAUSE_ECALL_M; exc_pc = 32'h302; exc_tval = 32'h0;
      mie = 1'b0; mpie = 1'b1;
      tick();
      clear_events();
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      chk("t3b_mcause", mcause_wd, 32'hB);
      chk("t3b_mepc", mepc_wd, 32'h300);
      chk("t3b_rpc", redir_pc, 32'h200);
      chk1("t3b_mpie", mpie_wd, 1'b0);
      tick();
      finish_redirect("t3b");

      // 4: drain timeout, then stalled redirect with a second exception waiting
      exc_valid = 1'b1; exc_cause = MCAUSE_STORE_FAULT; exc_pc = 32'h400; exc_tval = 32'h9;
      tick();
      exc_valid = 1'b0;
      n = 0;
      while (flush_req && n < 40) begin
         tick();
         n++;
      end
      chk("t4_drain_cycles", 32'(n), 32'd16);
      chk1("t4_we", csr_trap_we, 1'b1);
      chk1("t4_to", drain_timeout, 1'b1);
      chk("t4_mcause", mcause_wd, 32'h7);
      tick();
      exc_valid = 1'b1; exc_cause = MCAUSE_LOAD_FAULT; exc_pc = 32'h500; exc_tval = 32'h1234;
      for (int i = 0; i < 5; i++) begin
         chk1("t4_rv_hold", redir_valid, 1'b1);
         chk("t4_rpc_hold", redir_pc, 32'h200);
         chk1("t6_not_ready", evt_ready, 1'b0);
         tick();
      end
      // 6: the held exception is only taken once back in IDLE
      finish_redirect("t4");
      chk1("t6_no_flush_yet", flush_req, 1'b0);
      tick();
      exc_valid = 1'b0;
      chk1("t6_flush", flush_req, 1'b1);
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      chk1("t6_we", csr_trap_we, 1'b1);
      chk("t6_mcause", mcause_wd, 32'h5);
      chk("t6_mepc", mepc_wd, 32'h500);
      chk("t6_mtval", mtval_wd, 32'h1234);
      chk1("t6_to_sticky", drain_timeout, 1'b1);
      tick();
      finish_redirect("t6");

      // 5a: reset during DRAIN abandons the trap
      exc_valid = 1'b1; exc_cause = MCAUSE_BREAKPOINT; exc_pc = 32'h600; exc_tval = 32'h0;
      tick();
      exc_valid = 1'b0;
      chk1("t5a_in_drain", flush_req, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("t5a_ready", evt_ready, 1'b1);
      chk1("t5a_flush", flush_req, 1'b0);
      chk1("t5a_we", csr_trap_we, 1'b0);
      chk1("t5a_to", drain_timeout, 1'b0);
      chk("t5a_mcause", mcause_wd, 32'h0);
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      chk1("t5a_no_commit", csr_trap_we, 1'b0);

      // 5b: reset during REDIRECT drops the redirect
      exc_valid = 1'b1; exc_cause = MCAUSE_ILLEGAL_INSTR; exc_pc = 32'h700; exc_tval = 32'h1;
      tick();
      exc_valid = 1'b0;
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      tick();
      chk1("t5b_in_redir", redir_valid, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("t5b_rv", redir_valid, 1'b0);
      chk1("t5b_ready", evt_ready, 1'b1);
      chk1("t5b_we", csr_trap_we, 1'b0);
      chk("t5b_rpc", redir_pc, 32'h0);
      chk("t5b_mepc", mepc_wd, 32'h0);
      tick();
      chk1("t5b_idle_flush", flush_req, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
